// File: rtl/sys_ctrl_pkg.sv
// Shared types and default geometry for the systolic-array sequencer.
package sys_ctrl_pkg;

    localparam int H_DEF  = 32;
    localparam int W_DEF  = 32;
    localparam int KW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sys_seq_ctrl_if.sv
// Job-control, weight and activation handshake bundle for sys_seq_ctrl.
interface sys_seq_ctrl_if
    import sys_ctrl_pkg::*;
#(
    parameter int H  = H_DEF,
    parameter int KW = KW_DEF
);

    // job control
    logic                 start;
    logic                 reuse_w;
    logic [KW-1:0]        k_len;
    logic                 abort;
    // weight-row and activation-vector handshakes
    logic                 w_valid;
    logic                 w_ready;
    logic                 a_valid;
    logic                 a_ready;
    // array mode controls and status
    logic                 load_w;
    logic [$clog2(H)-1:0] row_sel;
    logic                 compute_en;
    logic                 drain_en;
    logic                 busy;
    logic                 done;
    logic                 w_resident;

    modport master (
        output start, reuse_w, k_len, abort, w_valid, a_valid,
        input  w_ready, a_ready, load_w, row_sel, compute_en, drain_en,
               busy, done, w_resident
    );

    modport slave (
        input  start, reuse_w, k_len, abort, w_valid, a_valid,
        output w_ready, a_ready, load_w, row_sel, compute_en, drain_en,
               busy, done, w_resident
    );

endinterface

// File: rtl/sys_cnt.sv
// Up-counter with synchronous clear and terminal-count compare.
module sys_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] tc_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + WIDTH'(1);
    end

    // count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/sys_seq_ctrl.sv
// Job sequencer for a systolic array: weight load, compute, drain, done.
module sys_seq_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int H  = H_DEF,
    parameter int W  = W_DEF,
    parameter int KW = KW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sys_seq_ctrl_if.slave  bus
);

    localparam int RW = $clog2(H);
    // drain count runs 0..H+W-2
    localparam int DW = $clog2(H + W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(H - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(H + W - 2);

    state_e        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic          w_res_q, w_res_d;

    logic          in_idle;
    logic          w_beat, a_beat;
    logic [RW-1:0] row_cnt;
    logic          row_tc;
    logic [KW-1:0] beat_cnt;
    logic          beat_tc;
    logic [DW-1:0] drain_cnt;
    logic          drain_tc;

    assign in_idle = (state_q == ST_IDLE);
    assign w_beat  = (state_q == ST_LOAD_W)  && bus.w_valid;
    assign a_beat  = (state_q == ST_COMPUTE) && bus.a_valid;

    // weight row pointer; wraps to 0 after the last row
    sys_cnt #(.WIDTH(RW)) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.abort || (w_beat && row_tc)),
        .en     (w_beat),
        .tc_val (ROW_LAST),
        .cnt    (row_cnt),
        .tc     (row_tc)
    );

    // activation beats; tc marks the beat that brings the count to k_len
    sys_cnt #(.WIDTH(KW)) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.abort || (a_beat && beat_tc)),
        .en     (a_beat),
        .tc_val (k_len_q - KW'(1)),
        .cnt    (beat_cnt),
        .tc     (beat_tc)
    );

    // drain cycles while skewed partial sums leave the array
    sys_cnt #(.WIDTH(DW)) u_drain_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.abort || ((state_q == ST_DRAIN) && drain_tc)),
        .en     (state_q == ST_DRAIN),
        .tc_val (DRAIN_LAST),
        .cnt    (drain_cnt),
        .tc     (drain_tc)
    );

    // next-state, job length latch and resident-weight tracking
    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        w_res_d = w_res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.abort) begin
                    w_res_d = 1'b0;
                end else if (bus.start) begin
                    k_len_d = bus.k_len;
                    if (bus.reuse_w && w_res_q) begin
                        state_d = (bus.k_len == '0) ? ST_DONE : ST_COMPUTE;
                    end else begin
                        // a partially overwritten array holds no valid set
                        state_d = ST_LOAD_W;
                        w_res_d = 1'b0;
                    end
                end
            end
            ST_LOAD_W: begin
                if (w_beat && row_tc) begin
                    w_res_d = 1'b1;
                    state_d = (k_len_q == '0) ? ST_DONE : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (a_beat && beat_tc)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_tc)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // cancel overrides any progress and invalidates the weights
        if (bus.abort && !in_idle) begin
            state_d = ST_IDLE;
            w_res_d = 1'b0;
        end
    end

    // state, latched job length and resident flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_len_q <= '0;
            w_res_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            w_res_q <= w_res_d;
        end
    end

    // mode outputs decode from state; compute_en follows the live handshake
    assign bus.load_w     = (state_q == ST_LOAD_W);
    assign bus.w_ready    = (state_q == ST_LOAD_W);
    assign bus.a_ready    = (state_q == ST_COMPUTE);
    assign bus.compute_en = bus.a_valid && bus.a_ready;
    assign bus.drain_en   = (state_q == ST_DRAIN);
    assign bus.busy       = !in_idle;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.w_resident = w_res_q;
    assign bus.row_sel    = row_cnt;

endmodule

// File: tb/tb_sys_seq_ctrl.sv
// Cycle-accurate scoreboard bench for sys_seq_ctrl at H=4, W=4.
module tb_sys_seq_ctrl;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int KW = 16;
    localparam int ND = H + W - 1;

    typedef struct packed {
        logic          start;
        logic          reuse;
        logic [KW-1:0] k;
        logic          abort;
        logic          wv;
        logic          av;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    stim_t      stim_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    sys_seq_ctrl_if #(.H(H), .KW(KW)) bus ();

    sys_seq_ctrl #(.H(H), .W(W), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // {busy, done, w_resident, load_w, w_ready, a_ready, compute_en, drain_en, row_sel}
    logic [9:0] obs;
    assign obs = {bus.busy, bus.done, bus.w_resident, bus.load_w, bus.w_ready,
                  bus.a_ready, bus.compute_en, bus.drain_en, bus.row_sel};

    function automatic stim_t mk(input logic st, input logic rw, input logic [KW-1:0] k,
                                 input logic ab, input logic wv, input logic av);
        stim_t s;
        s.start = st; s.reuse = rw; s.k = k; s.abort = ab; s.wv = wv; s.av = av;
        return s;
    endfunction

    function automatic logic [9:0] e_idle(input logic wr);
        return {1'b0, 1'b0, wr, 7'b0};
    endfunction
    function automatic logic [9:0] e_load(input logic [1:0] r);
        return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, r};
    endfunction
    function automatic logic [9:0] e_comp(input logic ce);
        return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ce, 1'b0, 2'b00};
    endfunction
    function automatic logic [9:0] e_drain(input logic wr);
        return {1'b1, 1'b0, wr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    endfunction
    function automatic logic [9:0] e_done();
        return {1'b1, 1'b1, 1'b1, 7'b0};
    endfunction

    task automatic push(input stim_t s, input logic [9:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        bus.start   = s.start;
        bus.reuse_w = s.reuse;
        bus.k_len   = s.k;
        bus.abort   = s.abort;
        bus.w_valid = s.wv;
        bus.a_valid = s.av;
    endtask

    // pops one stimulus/expectation pair per cycle and checks the outputs
    task automatic run_queue(input string name);
        stim_t      s;
        logic [9:0] e;
        int         cyc = 0;
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            apply(s);
            #1;
            n_total++;
            if (obs !== e)
                $display("FAIL %s cyc%0d: outputs=%b expected=%b", name, cyc, obs, e);
            else
                n_pass++;
            n_total++;
            if (!($countones({bus.load_w, bus.a_ready, bus.drain_en}) <= 1 &&
                  bus.w_ready === bus.load_w && (!bus.compute_en || bus.a_ready)))
                $display("FAIL %s_excl cyc%0d: outputs=%b expected mutually exclusive modes",
                         name, cyc, obs);
            else
                n_pass++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        apply(mk(1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 1'b1));
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (obs !== 10'b0) $display("FAIL reset_hold: outputs=%b expected=%b", obs, 10'b0);
        else n_pass++;
        @(negedge clk);
        apply(mk(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        n_total++;
        if (obs !== 10'b0) $display("FAIL reset_release: outputs=%b expected=%b", obs, 10'b0);
        else n_pass++;
    endtask

    task automatic test_basic();
        push(mk(1, 0, 16'd3, 0, 1, 1), e_idle(0));
        for (int r = 0; r < H; r++) push(mk(0, 0, 0, 0, 1, 1), e_load(2'(r)));
        for (int i = 0; i < 3; i++) push(mk(0, 0, 0, 0, 1, 1), e_comp(1));
        for (int i = 0; i < ND; i++) push(mk(0, 0, 0, 0, 1, 1), e_drain(1));
        push(mk(0, 0, 0, 0, 1, 1), e_done());
        push(mk(0, 0, 0, 0, 0, 0), e_idle(1));
        run_queue("basic");
    endtask

    task automatic test_reuse();
        push(mk(1, 1, 16'd2, 0, 0, 1), e_idle(1));
        for (int i = 0; i < 2; i++) push(mk(0, 0, 0, 0, 0, 1), e_comp(1));
        for (int i = 0; i < ND; i++) push(mk(0, 0, 0, 0, 0, 0), e_drain(1));
        push(mk(0, 0, 0, 0, 0, 0), e_done());
        push(mk(0, 0, 0, 0, 0, 0), e_idle(1));
        run_queue("reuse");
    endtask

    task automatic test_k0();
        push(mk(1, 0, 16'd0, 0, 1, 1), e_idle(1));
        for (int r = 0; r < H; r++) push(mk(0, 0, 0, 0, 1, 1), e_load(2'(r)));
        push(mk(0, 0, 0, 0, 1, 1), e_done());
        push(mk(0, 0, 0, 0, 0, 0), e_idle(1));
        run_queue("k0");
    endtask

    task automatic test_stall();
        push(mk(1, 0, 16'd1, 0, 1, 0), e_idle(1));
        push(mk(0, 0, 0, 0, 1, 0), e_load(2'd0));
        push(mk(0, 0, 0, 0, 1, 0), e_load(2'd1));
        for (int i = 0; i < 5; i++) push(mk(0, 0, 0, 0, 0, 0), e_load(2'd2));
        push(mk(0, 0, 0, 0, 1, 0), e_load(2'd2));
        push(mk(0, 1, 0, 0, 1, 0), e_load(2'd3));
        push(mk(1, 0, 16'd9, 0, 0, 0), e_comp(0));
        push(mk(0, 0, 0, 0, 0, 1), e_comp(1));
        for (int i = 0; i < ND; i++) push(mk(i == 0, 0, 0, 0, 0, 1), e_drain(1));
        push(mk(0, 0, 0, 0, 0, 0), e_done());
        push(mk(0, 0, 0, 0, 0, 0), e_idle(1));
        run_queue("stall");
    endtask

    task automatic test_abort();
        push(mk(1, 1, 16'd1, 0, 0, 1), e_idle(1));
        push(mk(0, 0, 0, 0, 0, 1), e_comp(1));
        push(mk(0, 0, 0, 0, 0, 0), e_drain(1));
        push(mk(0, 0, 0, 1, 0, 0), e_drain(1));
        push(mk(0, 0, 0, 0, 0, 0), e_idle(0));
        push(mk(0, 0, 0, 0, 0, 0), e_idle(0));
        push(mk(1, 1, 16'd1, 0, 1, 1), e_idle(0));
        for (int r = 0; r < H; r++) push(mk(0, 0, 0, 0, 1, 1), e_load(2'(r)));
        push(mk(0, 0, 0, 0, 0, 1), e_comp(1));
        for (int i = 0; i < ND; i++) push(mk(0, 0, 0, 0, 0, 0), e_drain(1));
        push(mk(0, 0, 0, 0, 0, 0), e_done());
        push(mk(1, 1, 16'd2, 1, 1, 1), e_idle(1));
        push(mk(0, 0, 0, 0, 0, 0), e_idle(0));
        push(mk(0, 0, 0, 0, 0, 0), e_idle(0));
        run_queue("abort");
    endtask

    task automatic test_reset_mid();
        // reload weights so the reset has a resident set to discard
        push(mk(1, 0, 16'd3, 0, 1, 0), e_idle(0));
        for (int r = 0; r < H; r++) push(mk(0, 0, 0, 0, 1, 0), e_load(2'(r)));
        push(mk(0, 0, 0, 0, 0, 1), e_comp(1));
        run_queue("reset_mid_setup");
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 1));
        #1;
        rst = 1'b0;
        #1;
        n_total++;
        if (obs !== 10'b0) $display("FAIL reset_mid_async: outputs=%b expected=%b", obs, 10'b0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (obs !== 10'b0)
                $display("FAIL reset_mid_idle%0d: outputs=%b expected=%b", i, obs, 10'b0);
            else
                n_pass++;
        end
        apply(mk(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reuse();
        test_k0();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sys_seq_ctrl.md
SYS_SEQ_CTRL -- requirements
Module: sys_seq_ctrl

Interface
REQ-001 Parameter H, default 32, systolic array height (weight rows); SHALL be >= 2.
REQ-002 Parameter W, default 32, systolic array width (columns); SHALL be >= 2.
REQ-003 Parameter KW, default 16, width of the compute-length field.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin one job; sampled only in IDLE.
REQ-007 reuse_w  input  1  with start: skip weight load if resident weights are valid.
REQ-008 k_len  input  KW  number of activation vectors in the job; sampled with start.
REQ-009 abort  input  1  synchronous job cancel.
REQ-010 w_valid / w_ready  input / output  1 / 1  weight-row handshake.
REQ-011 a_valid / a_ready  input / output  1 / 1  activation-vector handshake.
REQ-012 load_w  output  1  array in weight-load mode.
REQ-013 row_sel  output  $clog2(H)  target row of the current weight beat.
REQ-014 compute_en  output  1  array in partial-sum mode; asserted for the accepted activation beat.
REQ-015 drain_en  output  1  array flushing skewed partial sums.
REQ-016 busy / done  output  1 / 1  job in progress / one-cycle completion pulse.
REQ-017 w_resident  output  1  a complete weight set is held in the array.

Function
REQ-018 States SHALL be IDLE, LOAD_W, COMPUTE, DRAIN and DONE.
REQ-019 IDLE with start=1 SHALL go to COMPUTE if reuse_w=1 and w_resident=1, otherwise to LOAD_W; k_len SHALL be latched in the same cycle.
REQ-020 LOAD_W: w_ready=1 and load_w=1; each w_valid&&w_ready beat SHALL increment row_sel, starting at 0.
REQ-021 The beat with row_sel=H-1 SHALL set w_resident and go to COMPUTE (or to DONE if k_len=0); row_sel SHALL then return to 0.
REQ-022 LOAD_W without w_valid SHALL hold state and row_sel (stall, no timeout).
REQ-023 COMPUTE: a_ready=1; each a_valid&&a_ready beat SHALL assert compute_en in that cycle and increment a KW-bit beat count.
REQ-024 The beat that makes the count equal k_len SHALL move to DRAIN; a_valid=0 SHALL stall.
REQ-025 k_len=0 SHALL skip COMPUTE and DRAIN and go directly to DONE.
REQ-026 DRAIN SHALL last exactly H+W-1 cycles with drain_en=1, then go to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, without a done pulse.
REQ-031 abort SHALL clear w_resident and all counters.
REQ-032 abort in IDLE SHALL clear w_resident only.
REQ-033 abort and start in the same IDLE cycle: abort SHALL win, and start SHALL be ignored.
REQ-034 w_ready, a_ready, load_w, compute_en and drain_en SHALL be mutually exclusive.
REQ-035 All outputs SHALL be registered or decoded from state only, except compute_en, which SHALL equal a_valid&&a_ready.

Reset
REQ-036 rst=0 SHALL asynchronously force state IDLE, all counters to 0, and w_resident=0.
REQ-037 During reset every output SHALL be 0.
REQ-038 Reset mid-job SHALL discard the job; no done pulse SHALL follow deassertion.

Structure
REQ-039 Package sys_ctrl_pkg SHALL hold the state enum and the default H, W and KW constants.
REQ-040 One sub-module, sys_cnt (parametrised width, clear, enable, terminal-count compare), SHALL implement the row, beat and drain counters.

Verification (H=4, W=4)
REQ-041 start, reuse_w=0, k_len=3, w_valid and a_valid held high -> 4 load_w cycles with row_sel 0..3, then 3 compute_en cycles, then 7 drain_en cycles, then done for 1 cycle; busy stays 1 throughout.
REQ-042 Second job with reuse_w=1, k_len=2 after REQ-041 -> no LOAD_W; COMPUTE starts the cycle after start.
REQ-043 k_len=0, reuse_w=0 -> 4 load cycles, then done the next cycle, with no compute_en and no drain_en.
REQ-044 w_valid low for 5 cycles at row_sel=2 -> row_sel holds at 2 and the state stays LOAD_W; the job completes normally once w_valid returns high.
REQ-045 abort at the 2nd drain cycle -> IDLE next cycle, no done, w_resident=0; a following reuse_w=1 start enters LOAD_W.
REQ-046 rst asserted in COMPUTE -> all outputs 0 immediately; after release the block is idle and w_resident=0.
